mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative, parametrised RV32M multiply/divide unit; sequential companion to the single-cycle combinational ALU in the execute stage.
- Accepts one operation per Start pulse and computes over multiple cycles.
- Signals Busy so the hazard unit stalls the pipeline, then pulses Done with a registered result.
- Supports all eight M-extension ops, including RISC-V divide-by-zero and overflow semantics.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >=8)
OPCODE_LENGTH, 3, Operation width; encoding equals RV32M funct3

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
Start  input  1  request; accepted only in IDLE or DONE
SrcA  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
SrcB  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Kill  input  1  abort in-flight op (pipeline flush)
Busy  output  1  high in CALC and FIX
Done  output  1  one-cycle pulse, Result valid
MDResult  output  DATA_WIDTH  registered result, held until next accepted op completes

Behaviour:
- Reset (reset=0 at edge): state=IDLE, Busy=0, Done=0, MDResult=0, counter=0, internal regs=0. Reset overrides Start/Kill and aborts any operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with Start=1: latch Operation and operand magnitudes; record signs.
  - Signed: DIV/REM/MULH both operands; MULHSU SrcA only.
  - Counter=DATA_WIDTH-1.
  - Next state CALC, unless a special case applies.
- Special cases go directly to DONE; Done is seen exactly one cycle after acceptance.
  - Divide by zero (SrcB=0): DIV/DIVU -> all ones; REM/REMU -> SrcA.
  - Signed overflow (DIV/REM, SrcA=most negative, SrcB=-1): DIV -> SrcA; REM -> 0.
- CALC: one step per cycle for DATA_WIDTH cycles.
  - Multiply: shift-add into 2*DATA_WIDTH-bit product.
  - Divide: restoring division, 1 quotient bit per cycle.
  - Counter decrements; at counter==0 go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation on sign mismatch. Quotient sign = signA^signB; remainder sign = signA.
  - Select result: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Write MDResult; go to DONE.
- DONE: Done=1 for this cycle only.
  - Start=1 -> accept new op (back-to-back, no bubble).
  - Otherwise -> IDLE.
- Latency: Start accepted at edge t -> Done high in cycle after edge t+DATA_WIDTH+1 (DATA_WIDTH+2 cycles total).
- Busy=1 exactly in CALC/FIX.
  - Start while Busy is ignored; latched operands are unaffected by input changes.
- Kill=1 in CALC/FIX: next state IDLE; no Done; MDResult unchanged.
  - Kill in IDLE/DONE has no effect on state except that a simultaneous Start is dropped (Kill wins).
- All arithmetic is modulo 2^DATA_WIDTH. Most-negative magnitude is handled as unsigned DATA_WIDTH value (no extra bit needed).
- Counter width: $clog2(DATA_WIDTH).

Decomposition:
- Package mul_div_pkg holds:
  - typedef enum for Operation (MD_MUL..MD_REMU, 3-bit, funct3 values).
  - typedef enum for state (IDLE, CALC, FIX, DONE).
  - Helper functions is_div(op) and is_signed_a/b(op).
- Single module; no sub-module. Datapath shares one DATA_WIDTH+1 adder/subtractor between multiply and divide steps.

Test Plan (DATA_WIDTH=32):
- MUL 7 * -3 (0xFFFFFFFD), Start one cycle -> Busy for 33 cycles, Done at cycle 34, MDResult=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1.
- DIVU 5/0 -> Done one cycle after Start, MDResult=0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Kill asserted at cycle 10 of a DIV -> IDLE next cycle, no Done, MDResult keeps previous value; new Start then completes normally.
- Start held high through Busy -> ignored; Start in DONE cycle -> second op accepted with no idle cycle, two Done pulses 34 cycles apart.
- reset=0 mid-CALC -> next edge Busy=0, Done=0, MDResult=0; Done never appears for the aborted op.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

  // Encoding matches the RV32M funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } md_state_e;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// sharing a single DATA_WIDTH+1 adder/subtractor.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     Kill,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    MDResult
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  md_state_e     state_q;
  md_op_e        op_q;
  logic          sign_a_q, sign_b_q;
  logic [W-1:0]  opnd_q;  // multiplicand or divisor magnitude
  logic [W-1:0]  hi_q;    // product high half / partial remainder
  logic [W-1:0]  lo_q;    // multiplier -> product low half / dividend -> quotient
  logic [CW-1:0] cnt_q;

  md_op_e       op_in;
  logic         sa_in, sb_in, div_zero, div_ovf;
  logic [W-1:0] mag_a, mag_b, special_res;

  always_comb begin
    op_in       = md_op_e'(Operation[2:0]);
    sa_in       = is_signed_a(op_in) & SrcA[W-1];
    sb_in       = is_signed_b(op_in) & SrcB[W-1];
    mag_a       = sa_in ? -SrcA : SrcA;
    mag_b       = sb_in ? -SrcB : SrcB;
    div_zero    = is_div(op_in) && (SrcB == '0);
    div_ovf     = is_div(op_in) && is_signed_a(op_in) && (SrcB == '1) &&
                  (SrcA == {1'b1, {(W-1){1'b0}}});
    special_res = '0;
    if (div_zero) begin
      special_res = op_in[1] ? SrcA : '1;
    end else if (div_ovf) begin
      special_res = op_in[1] ? '0 : SrcA;
    end
  end

  logic [W:0]     add_x, add_y, add_s, psum;
  logic [W-1:0]   hi_n, lo_n, quo_fix, rem_fix, fix_res;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    add_x = is_div(op_q) ? {hi_q, lo_q[W-1]} : {1'b0, hi_q};
    add_y = {1'b0, opnd_q};
    add_s = is_div(op_q) ? add_x - add_y : add_x + add_y;
    psum  = lo_q[0] ? add_s : {1'b0, hi_q};
    if (is_div(op_q)) begin
      // Borrow out of the top bit means the trial subtraction failed: restore.
      hi_n = add_s[W] ? add_x[W-1:0] : add_s[W-1:0];
      lo_n = {lo_q[W-2:0], ~add_s[W]};
    end else begin
      hi_n = psum[W:1];
      lo_n = {psum[0], lo_q[W-1:1]};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix  = sign_a_q ? -hi_q : hi_q;
    fix_res  = rem_fix;
    case (op_q)
      MD_MUL:                       fix_res = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      MDResult <= '0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (Start && !Kill) begin
            op_q     <= op_in;
            sign_a_q <= sa_in;
            sign_b_q <= sb_in;
            opnd_q   <= is_div(op_in) ? mag_b : mag_a;
            lo_q     <= is_div(op_in) ? mag_a : mag_b;
            hi_q     <= '0;
            cnt_q    <= CW'(W - 1);
            if (div_zero || div_ovf) begin
              MDResult <= special_res;
              Done     <= 1'b1;
              Busy     <= 1'b0;
              state_q  <= StDone;
            end else begin
              Busy    <= 1'b1;
              state_q <= StCalc;
            end
          end else begin
            Busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StCalc: begin
          if (Kill) begin
            Busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) state_q <= StFix;
          end
        end
        default: begin  // StFix
          Busy <= 1'b0;
          if (Kill) begin
            state_q <= StIdle;
          end else begin
            MDResult <= fix_res;
            Done     <= 1'b1;
            state_q  <= StDone;
          end
        end
      endcase
    end
  end

endmodule
